// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the ROM arbiter: phase state encodings, master
// indices and a small index-to-one-hot helper.
package rom_arbiter_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// One AHB-lite style read channel. The requester side uses the master
// modport; the responder side uses the slave modport.
interface rom_arbiter_if
    import rom_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    logic [DATA_W-1:0] hrdata;
    logic              hready;
    logic              hresp;

    modport master (output hsel, haddr, input hrdata, hready, hresp);
    modport slave  (input hsel, haddr, output hrdata, hready, hresp);
endinterface

// File: rtl/rom_arbiter_pick.sv
// Two-way request picker: eligible vector in, one-hot winner out.
// Build option ROM_ARB_RR_EN selects round-robin on contention (the master
// not granted last wins); otherwise M1 always beats M0.
module rom_arbiter_pick
    import rom_arbiter_pkg::*;
(
    input  logic [1:0] eligible,
`ifdef ROM_ARB_RR_EN
    input  logic       last_grant,
`endif
    output logic [1:0] winner
);

    // A lone requester wins outright; contention is resolved by the policy.
    always_comb begin
        winner = eligible;
        if (eligible == 2'b11) begin
`ifdef ROM_ARB_RR_EN
            winner = onehot(~last_grant);
`else
            winner = onehot(M1);
`endif
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Shares a single-ported boot ROM between M0 (fetch) and M1 (data load).
// Decodes the ROM window, arbitrates, routes the one-cycle-latency read data
// back to the owner and answers out-of-window accesses with a two-cycle
// error without touching the ROM.
// Build option ROM_ARB_RR_EN: round-robin arbitration instead of fixed M1>M0.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int          AWIDTH = 8,
    parameter logic [31:0] BASE   = 32'h0000_0000
)(
    input  logic              HCLK_I,
    input  logic              HRESET_I,
    rom_arbiter_if.slave      m0,
    rom_arbiter_if.slave      m1,
    rom_arbiter_if.master     rom,
    output logic              ROM_HREADY_O,
    output logic [1:0]        GRANT_O
);

    logic [1:0]        state, state_nxt;
    logic              owner, owner_nxt;
    logic              busy;
    logic              can_arb;
    logic [1:0]        eligible;
    logic [1:0]        winner;
    logic              grant_valid;
    logic              win_idx;
    logic [31:0]       win_addr;
    logic              in_win;
    logic              rom_sel;
    logic              ph_ready;
    logic              ph_resp;
    logic [DATA_W-1:0] ph_data;

    assign busy = (state != ST_IDLE);

    // The owner of a running phase may not be re-granted in the cycle that
    // phase completes, which is what hands the slot to the other master.
    assign eligible[0] = m0.hsel & ~(busy & (owner == M0));
    assign eligible[1] = m1.hsel & ~(busy & (owner == M1));

    // New grants only where the ROM address phase is free; reset blocks them
    // so ROM_HSEL_O drops as soon as reset rises.
    assign can_arb = ~HRESET_I &
                     ((state == ST_IDLE) ||
                      ((state == ST_DATA) && rom.hready) ||
                      (state == ST_ERR2));

`ifdef ROM_ARB_RR_EN
    logic last_grant;

    // Remember who was granted last; starts favouring M0 out of reset.
    always_ff @(posedge HCLK_I or posedge HRESET_I) begin
        if (HRESET_I)
            last_grant <= M1;
        else if (grant_valid)
            last_grant <= win_idx;
    end

    rom_arbiter_pick u_pick (
        .eligible   (eligible & {2{can_arb}}),
        .last_grant (last_grant),
        .winner     (winner)
    );
`else
    rom_arbiter_pick u_pick (
        .eligible (eligible & {2{can_arb}}),
        .winner   (winner)
    );
`endif

    assign grant_valid = |winner;
    assign win_idx     = winner[1];
    assign win_addr    = win_idx ? m1.haddr : m0.haddr;
    assign in_win      = (win_addr[31:AWIDTH] == BASE[31:AWIDTH]);
    assign rom_sel     = grant_valid & in_win;

    assign rom.hsel     = rom_sel;
    assign rom.haddr    = rom_sel ? win_addr[AWIDTH-1:0] : '0;
    assign ROM_HREADY_O = 1'b1;

    // Next phase: a grant starts a ROM data phase or an error phase,
    // otherwise finished phases fall back to idle.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        if (grant_valid) begin
            state_nxt = in_win ? ST_DATA : ST_ERR1;
            owner_nxt = win_idx;
        end else begin
            case (state)
                ST_DATA: if (rom.hready) state_nxt = ST_IDLE;
                ST_ERR1: state_nxt = ST_ERR2;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Phase state and owner; reset drops any in-flight access.
    always_ff @(posedge HCLK_I or posedge HRESET_I) begin
        if (HRESET_I) begin
            state <= ST_IDLE;
            owner <= M0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    // Response seen by the owner in the current phase.
    always_comb begin
        ph_ready = 1'b0;
        ph_resp  = 1'b0;
        ph_data  = '0;
        case (state)
            ST_DATA: begin
                ph_ready = rom.hready;
                ph_resp  = rom.hresp;
                ph_data  = rom.hready ? rom.hrdata : '0;
            end
            ST_ERR1: ph_resp = 1'b1;
            ST_ERR2: begin
                ph_ready = 1'b1;
                ph_resp  = 1'b1;
            end
            default: ;
        endcase
    end

    assign GRANT_O = busy ? onehot(owner) : 2'b00;

    assign m0.hready = GRANT_O[0] & ph_ready;
    assign m0.hresp  = GRANT_O[0] & ph_resp;
    assign m0.hrdata = GRANT_O[0] ? ph_data : '0;
    assign m1.hready = GRANT_O[1] & ph_ready;
    assign m1.hresp  = GRANT_O[1] & ph_resp;
    assign m1.hrdata = GRANT_O[1] ? ph_data : '0;

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter in its default (fixed-priority) build.
// A small ROM model returns 32'hDA7A_0000 + word_index * 32'h0101.
module tb_rom_arbiter;

    typedef struct {
        string       name;
        logic        s0;
        logic [31:0] a0;
        logic        s1;
        logic [31:0] a1;
        logic        rdy;
        logic        e_rsel;
        logic [7:0]  e_raddr;
        logic [1:0]  e_gnt;
        logic        e_r0;
        logic        e_p0;
        logic [31:0] e_d0;
        logic        e_r1;
        logic        e_p1;
        logic [31:0] e_d1;
    } vec_t;

    localparam int NV = 26;

    logic        HCLK_I = 1'b0;
    logic        HRESET_I;
    logic        rom_hready_o;
    logic [1:0]  grant;
    logic [31:0] rom_q;
    int          checks = 0;
    int          failures = 0;
    vec_t        vecs [NV];

    rom_arbiter_if #(.ADDR_W(32)) m0_bus ();
    rom_arbiter_if #(.ADDR_W(32)) m1_bus ();
    rom_arbiter_if #(.ADDR_W(8))  rom_bus ();

    rom_arbiter #(.AWIDTH(8), .BASE(32'h0000_0000)) dut (
        .HCLK_I       (HCLK_I),
        .HRESET_I     (HRESET_I),
        .m0           (m0_bus),
        .m1           (m1_bus),
        .rom          (rom_bus),
        .ROM_HREADY_O (rom_hready_o),
        .GRANT_O      (grant)
    );

    always #5 HCLK_I = ~HCLK_I;

    function automatic logic [31:0] romWord(input logic [7:0] a);
        logic [5:0] idx;
        idx = a[7:2];
        return 32'hDA7A_0000 + 32'(idx) * 32'h0101;
    endfunction

    // ROM model: one-cycle read latency, captures on its select.
    always @(posedge HCLK_I) begin
        if (rom_bus.hsel)
            rom_q <= romWord(rom_bus.haddr);
    end
    assign rom_bus.hrdata = rom_q;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic s0, input logic [31:0] a0,
                                 input logic s1, input logic [31:0] a1, input logic rdy);
        @(posedge HCLK_I);
        #1;
        m0_bus.hsel    = s0;
        m0_bus.haddr   = a0;
        m1_bus.hsel    = s1;
        m1_bus.haddr   = a1;
        rom_bus.hready = rdy;
    endtask

    task automatic checkAll(input string n, input logic rsel, input logic [7:0] raddr,
                            input logic [1:0] gnt, input logic r0, input logic p0,
                            input logic [31:0] d0, input logic r1, input logic p1,
                            input logic [31:0] d1);
        checkOutput({n, " rom_hsel"},  32'(rom_bus.hsel),  32'(rsel));
        checkOutput({n, " rom_haddr"}, 32'(rom_bus.haddr), 32'(raddr));
        checkOutput({n, " grant"},     32'(grant),         32'(gnt));
        checkOutput({n, " m0_hready"}, 32'(m0_bus.hready), 32'(r0));
        checkOutput({n, " m0_hresp"},  32'(m0_bus.hresp),  32'(p0));
        checkOutput({n, " m0_hrdata"}, m0_bus.hrdata,      d0);
        checkOutput({n, " m1_hready"}, 32'(m1_bus.hready), 32'(r1));
        checkOutput({n, " m1_hresp"},  32'(m1_bus.hresp),  32'(p1));
        checkOutput({n, " m1_hrdata"}, m1_bus.hrdata,      d1);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int m0_pulses;

        //           name            s0    a0          s1    a1          rdy   rsel  raddr  gnt    r0    p0    d0              r1    p1    d1
        vecs[0]  = '{"t1 issue",     1'b1, 32'h04,     1'b0, 32'h0,      1'b1, 1'b1, 8'h04, 2'b00, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0};
        vecs[1]  = '{"t1 data",      1'b1, 32'h04,     1'b0, 32'h0,      1'b1, 1'b0, 8'h00, 2'b01, 1'b1, 1'b0, 32'hDA7A_0101,  1'b0, 1'b0, 32'h0};
        vecs[2]  = '{"t1 idle",      1'b0, 32'h0,      1'b0, 32'h0,      1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0};
        vecs[3]  = '{"t2 both",      1'b1, 32'h08,     1'b1, 32'h0C,     1'b1, 1'b1, 8'h0C, 2'b00, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0};
        vecs[4]  = '{"t2 m1 done",   1'b1, 32'h08,     1'b1, 32'h0C,     1'b1, 1'b1, 8'h08, 2'b10, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'hDA7A_0303};
        vecs[5]  = '{"t2 m0 done",   1'b1, 32'h08,     1'b0, 32'h0,      1'b1, 1'b0, 8'h00, 2'b01, 1'b1, 1'b0, 32'hDA7A_0202,  1'b0, 1'b0, 32'h0};
        vecs[6]  = '{"t2 idle",      1'b0, 32'h0,      1'b0, 32'h0,      1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0};
        vecs[7]  = '{"t3 miss",      1'b1, 32'h100,    1'b0, 32'h0,      1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0};
        vecs[8]  = '{"t3 err1",      1'b1, 32'h100,    1'b0, 32'h0,      1'b1, 1'b0, 8'h00, 2'b01, 1'b0, 1'b1, 32'h0,          1'b0, 1'b0, 32'h0};
        vecs[9]  = '{"t3 err2",      1'b1, 32'h100,    1'b0, 32'h0,      1'b1, 1'b0, 8'h00, 2'b01, 1'b1, 1'b1, 32'h0,          1'b0, 1'b0, 32'h0};
        vecs[10] = '{"t3 idle",      1'b0, 32'h0,      1'b0, 32'h0,      1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0};
        vecs[11] = '{"t6 issue",     1'b0, 32'h0,      1'b1, 32'h10,     1'b1, 1'b1, 8'h10, 2'b00, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0};
        vecs[12] = '{"t6 stall1",    1'b1, 32'h14,     1'b1, 32'h10,     1'b0, 1'b0, 8'h00, 2'b10, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0};
        vecs[13] = '{"t6 stall2",    1'b1, 32'h14,     1'b1, 32'h10,     1'b0, 1'b0, 8'h00, 2'b10, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0};
        vecs[14] = '{"t6 stall3",    1'b1, 32'h14,     1'b1, 32'h10,     1'b0, 1'b0, 8'h00, 2'b10, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0};
        vecs[15] = '{"t6 release",   1'b1, 32'h14,     1'b1, 32'h10,     1'b1, 1'b1, 8'h14, 2'b10, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'hDA7A_0404};
        vecs[16] = '{"t6 m0 done",   1'b1, 32'h14,     1'b0, 32'h0,      1'b1, 1'b0, 8'h00, 2'b01, 1'b1, 1'b0, 32'hDA7A_0505,  1'b0, 1'b0, 32'h0};
        vecs[17] = '{"t6 idle",      1'b0, 32'h0,      1'b0, 32'h0,      1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0};
        vecs[18] = '{"m1 miss",      1'b0, 32'h0,      1'b1, 32'h200,    1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0};
        vecs[19] = '{"m1 err1",      1'b1, 32'h18,     1'b1, 32'h200,    1'b1, 1'b0, 8'h00, 2'b10, 1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h0};
        vecs[20] = '{"m1 err2",      1'b1, 32'h18,     1'b1, 32'h200,    1'b1, 1'b1, 8'h18, 2'b10, 1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 32'h0};
        vecs[21] = '{"m0 after err", 1'b1, 32'h18,     1'b0, 32'h0,      1'b1, 1'b0, 8'h00, 2'b01, 1'b1, 1'b0, 32'hDA7A_0606,  1'b0, 1'b0, 32'h0};
        vecs[22] = '{"err idle",     1'b0, 32'h0,      1'b0, 32'h0,      1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0};
        vecs[23] = '{"top word",     1'b1, 32'hFC,     1'b0, 32'h0,      1'b1, 1'b1, 8'hFC, 2'b00, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0};
        vecs[24] = '{"top data",     1'b1, 32'hFC,     1'b0, 32'h0,      1'b1, 1'b0, 8'h00, 2'b01, 1'b1, 1'b0, 32'hDA7A_3F3F,  1'b0, 1'b0, 32'h0};
        vecs[25] = '{"top idle",     1'b0, 32'h0,      1'b0, 32'h0,      1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0};

        // Reset state, with M0 already requesting to show reset blocks it.
        HRESET_I       = 1'b1;
        rom_q          = 32'h0;
        rom_bus.hready = 1'b1;
        rom_bus.hresp  = 1'b0;
        m0_bus.hsel    = 1'b1;
        m0_bus.haddr   = 32'h04;
        m1_bus.hsel    = 1'b0;
        m1_bus.haddr   = 32'h0;
        @(negedge HCLK_I);
        checkAll("reset", 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("reset rom_hready_o", 32'(rom_hready_o), 32'h1);
        m0_bus.hsel = 1'b0;
        @(posedge HCLK_I);
        #1;
        HRESET_I = 1'b0;

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].s0, vecs[i].a0, vecs[i].s1, vecs[i].a1, vecs[i].rdy);
            @(negedge HCLK_I);
            checkAll(vecs[i].name, vecs[i].e_rsel, vecs[i].e_raddr, vecs[i].e_gnt,
                     vecs[i].e_r0, vecs[i].e_p0, vecs[i].e_d0,
                     vecs[i].e_r1, vecs[i].e_p1, vecs[i].e_d1);
        end

        // Both masters request without pause: owner exclusion gives the
        // address slot to the other master each cycle, M1 first.
        m0_pulses = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b1, 32'h24, 1'b1, 32'h20, 1'b1);
            @(negedge HCLK_I);
            checkOutput($sformatf("t4 c%0d rom_hsel", c), 32'(rom_bus.hsel), 32'h1);
            checkOutput($sformatf("t4 c%0d rom_haddr", c), 32'(rom_bus.haddr),
                        (c % 2 == 0) ? 32'h20 : 32'h24);
            if (c == 0)
                checkOutput("t4 c0 grant", 32'(grant), 32'h0);
            else if (c % 2 == 1)
                checkOutput($sformatf("t4 c%0d m1 data", c), m1_bus.hrdata, 32'hDA7A_0808);
            else
                checkOutput($sformatf("t4 c%0d m0 data", c), m0_bus.hrdata, 32'hDA7A_0909);
            if (m0_bus.hready)
                m0_pulses++;
        end
        checkOutput("t4 m0 pulses", 32'(m0_pulses), 32'd9);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

        // Reset in the middle of a data phase drops it at once.
        applyStimulus(1'b1, 32'h08, 1'b0, 32'h0, 1'b1);
        @(negedge HCLK_I);
        checkOutput("t5 issue rom_hsel", 32'(rom_bus.hsel), 32'h1);
        @(posedge HCLK_I);
        #1;
        m1_bus.hsel  = 1'b1;
        m1_bus.haddr = 32'h0C;
        HRESET_I     = 1'b1;
        #1;
        checkAll("t5 in reset", 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge HCLK_I);
        m0_bus.hsel = 1'b0;
        m1_bus.hsel = 1'b0;
        HRESET_I    = 1'b0;
        applyStimulus(1'b1, 32'h08, 1'b0, 32'h0, 1'b1);
        @(negedge HCLK_I);
        checkAll("t5 reissue", 1'b1, 8'h08, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h08, 1'b0, 32'h0, 1'b1);
        @(negedge HCLK_I);
        checkAll("t5 data", 1'b0, 8'h00, 2'b01, 1'b1, 1'b0, 32'hDA7A_0202, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
